// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package serial_addsub_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Width of the nibble index counter; a single-nibble build still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_addsub_slice.sv
// One nibble of the serial add/subtract; B arrives already conditionally inverted.
module nibble_addsub_slice
  import serial_addsub_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                sum_msb
);

  ripple_adder4 u_adder (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  // Sign bit of this nibble's sum, used for overflow on the top nibble.
  assign sum_msb = sum[NIBBLE_W-1];

endmodule

// File: rtl/ripple_adder4.sv
// 4-bit ripple-carry adder: the shared arithmetic datapath slice.
module ripple_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  // One full adder per bit, carry rippling upward.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[4];

endmodule

// File: rtl/serial_addsub_ctrl.sv
// W-bit add/subtract sequenced over a single 4-bit slice, LSB nibble first,
// with valid/ready handshakes on both sides and carry/overflow/zero flags.
module serial_addsub_ctrl
  import serial_addsub_ctrl_pkg::*;
#(
  parameter int unsigned N_NIBBLES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            sub,
  input  logic [NIBBLE_W*N_NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*N_NIBBLES-1:0]   b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NIBBLE_W*N_NIBBLES-1:0]   result,
  output logic                            cout,
  output logic                            ovf,
  output logic                            zero
);

  localparam int unsigned W     = NIBBLE_W * N_NIBBLES;
  localparam int unsigned IDX_W = idx_width(N_NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIBBLES - 1);

  state_t state;
  state_t state_next;

  logic [W-1:0]        a_reg;
  logic [W-1:0]        b_reg;
  logic [W-1:0]        acc_reg;
  logic [W-1:0]        acc_next;
  logic                carry_reg;
  logic [IDX_W-1:0]    idx;

  logic                accept;
  logic                step;
  logic                last;

  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic                slice_msb;

  nibble_addsub_slice u_slice (
    .a       (a_reg[NIBBLE_W-1:0]),
    .b       (b_reg[NIBBLE_W-1:0]),
    .cin     (carry_reg),
    .sum     (slice_sum),
    .cout    (slice_cout),
    .sum_msb (slice_msb)
  );

  // New sum nibble enters at the top; after the last slice the result is aligned.
  if (N_NIBBLES == 1) begin : g_acc_single
    assign acc_next = slice_sum;
  end else begin : g_acc_multi
    assign acc_next = {slice_sum, acc_reg[W-1:NIBBLE_W]};
  end

  assign last      = (idx == LAST_IDX);
  assign out_valid = (state == OUT);
  // The OUT cycle doubles as an accept cycle when the consumer takes the result.
  assign in_ready  = (state == IDLE) || ((state == OUT) && out_ready);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_next = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (in_valid) begin
            accept     = 1'b1;
            state_next = RUN;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, nibble shifting and flag capture on the final slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b ^ {W{sub}};
      carry_reg <= sub;
      idx       <= '0;
    end else if (step) begin
      a_reg     <= a_reg >> NIBBLE_W;
      b_reg     <= b_reg >> NIBBLE_W;
      acc_reg   <= acc_next;
      carry_reg <= slice_cout;
      idx       <= idx + IDX_W'(1);
      if (last) begin
        result <= acc_next;
        cout   <= slice_cout;
        ovf    <= (a_reg[NIBBLE_W-1] == b_reg[NIBBLE_W-1]) &&
                  (slice_msb != a_reg[NIBBLE_W-1]);
        zero   <= (acc_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: directed table, handshake corner
// sequences, mid-operation reset, randomized traffic and a single-nibble build.
module tb_serial_addsub_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, zero;
  logic [15:0] a, b, result;

  logic        in_valid1, in_ready1, sub1, out_valid1, out_ready1, cout1, ovf1, zero1;
  logic [3:0]  a1, b1, result1;

  int n_cmp = 0;
  int n_bad = 0;

  serial_addsub_ctrl #(.N_NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .ovf(ovf), .zero(zero)
  );

  serial_addsub_ctrl #(.N_NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .sub(sub1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1), .result(result1),
    .cout(cout1), .ovf(ovf1), .zero(zero1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] r;
    logic        c;
    logic        o;
    logic        z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: integer arithmetic on unsigned and signed views of the operands.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic ms,
                                output logic [15:0] r, output logic c, output logic o,
                                output logic z);
    int ua, ub, sa, sb, tot, st;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (!ms) begin
      tot = ua + ub;
      c   = (tot >= 65536);
      st  = sa + sb;
    end else begin
      tot = ua - ub;
      c   = (ua >= ub);
      st  = sa - sb;
    end
    r = 16'(tot);
    o = (st > 32767) || (st < -32768);
    z = (r == 16'h0000);
  endfunction

  // One operation: accept, count edges to out_valid, stall 'hold' cycles, take.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic is,
                        input int hold, output int lat, output logic [15:0] r,
                        output logic c, output logic o, output logic z);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick;
      w++;
    end
    chk("in_ready_idle", in_ready, 1);
    a = ia; b = ib; sub = is; in_valid = 1'b1;
    lat = 0;
    do begin
      tick;
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      end
    end while (!out_valid && lat < 30);
    r = result; c = cout; o = ovf; z = zero;
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_result_stable", result, r);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic run1(input logic [3:0] ia, input logic [3:0] ib, input logic is,
                      output int lat);
    a1 = ia; b1 = ib; sub1 = is; in_valid1 = 1'b1;
    lat = 0;
    do begin
      tick;
      lat++;
      if (lat == 1) in_valid1 = 1'b0;
    end while (!out_valid1 && lat < 30);
  endtask

  initial begin
    vec_t        tbl[7];
    int          lat;
    int          seen;
    logic [15:0] r, er;
    logic        c, o, z, ec, eo, ez;

    tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0; sub = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0; out_ready1 = 1'b0;
    repeat (2) tick;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {cout, ovf, zero}, 0);
    rst = 1'b0;
    tick;
    chk("rst_in_ready", in_ready, 1);

    // Directed table.
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, i % 3, lat, r, c, o, z);
      chk($sformatf("tbl%0d_latency", i), lat, 5);
      chk($sformatf("tbl%0d_result", i), r, tbl[i].r);
      chk($sformatf("tbl%0d_cout", i), c, tbl[i].c);
      chk($sformatf("tbl%0d_ovf", i), o, tbl[i].o);
      chk($sformatf("tbl%0d_zero", i), z, tbl[i].z);
    end

    // Backpressure in OUT, then back-to-back accept on the taking edge.
    a = 16'h1111; b = 16'h2222; sub = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    chk("bp_out_valid", out_valid, 1);
    chk("bp_result", result, 16'h3333);
    a = 16'h0100; b = 16'h0001; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_hold_result", result, 16'h3333);
      chk("bp_hold_valid", out_valid, 1);
      tick;
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", in_ready, 1);
    tick;
    out_ready = 1'b0; in_valid = 1'b0;
    chk("b2b_running", out_valid, 0);
    lat = 1;
    while (!out_valid && lat < 30) begin
      tick;
      lat++;
    end
    chk("b2b_latency", lat, 5);
    chk("b2b_result", result, 16'h00FF);
    chk("b2b_cout", cout, 1);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;

    // in_valid held through RUN must not queue a second operation.
    a = 16'h0003; b = 16'h0004; sub = 1'b0; in_valid = 1'b1;
    repeat (5) tick;
    chk("noq_result", result, 16'h0007);
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    seen = 0;
    repeat (8) begin
      tick;
      if (out_valid) seen++;
    end
    chk("noq_no_extra_valid", seen, 0);

    // Reset mid-RUN discards the operation and clears outputs immediately.
    a = 16'h4444; b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_flags", {cout, ovf, zero}, 0);
    tick;
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      tick;
      if (out_valid) seen++;
    end
    chk("midrst_no_valid", seen, 0);
    run_op(16'h0001, 16'h0001, 1'b0, 0, lat, r, c, o, z);
    chk("postrst_latency", lat, 5);
    chk("postrst_result", r, 16'h0002);

    // Randomized traffic against the arithmetic model.
    for (int k = 0; k < 300; k++) begin
      logic [15:0] ra, rb;
      logic        rs;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (k % 10 == 0) rb = ra;
      rs = 1'($urandom);
      model(ra, rb, rs, er, ec, eo, ez);
      run_op(ra, rb, rs, int'($urandom_range(0, 2)), lat, r, c, o, z);
      chk("rnd_latency", lat, 5);
      chk("rnd_result", r, er);
      chk("rnd_flags", {c, o, z}, {ec, eo, ez});
    end

    // Single-nibble build.
    run1(4'hF, 4'h1, 1'b0, lat);
    chk("n1_latency", lat, 2);
    chk("n1_result", result1, 4'h0);
    chk("n1_cout_zero", {cout1, zero1}, 2'b11);
    out_ready1 = 1'b1;
    tick;
    out_ready1 = 1'b0;
    run1(4'h7, 4'h1, 1'b0, lat);
    chk("n1_ovf_result", result1, 4'h8);
    chk("n1_ovf_flags", {cout1, ovf1, zero1}, 3'b010);
    out_ready1 = 1'b1;
    tick;
    out_ready1 = 1'b0;
    run1(4'h3, 4'h5, 1'b1, lat);
    chk("n1_sub_result", result1, 4'hE);
    chk("n1_sub_flags", {cout1, ovf1, zero1}, 3'b000);
    chk("n1_sub_latency", lat, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_addsub_ctrl.md
# serial_addsub_ctrl

Sequencer that performs W-bit two's-complement add/subtract by time-multiplexing a single 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first. It sits between a producer issuing operand pairs and a consumer taking results, so wide arithmetic runs on the team's existing 4-bit adder datapath without replicating it. The block adds a valid/ready handshake on both sides, a carry/borrow register, and status flags.

## Interface
- N_NIBBLES, 4: number of 4-bit slices; W = 4*N_NIBBLES (16 by default); legal range 1..16.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts operands this cycle.
- sub  in  1  0 = A+B, 1 = A-B; sampled with operands.
- a  in  W  operand A.
- b  in  W  operand B.
- out_valid  out  1  result and flags valid; held until taken.
- out_ready  in  1  consumer takes the result.
- result  out  W  sum/difference, modulo 2^W.
- cout  out  1  final carry out; for subtract, 1 = no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  result == 0.

## Operation
- FSM states: IDLE, RUN, OUT.
- IDLE: in_ready=1. On in_valid: latch a, b^{W{sub}}, sub; carry_reg<=sub; idx<=0; go to RUN.
- RUN: slice adds a_reg[3:0], b_reg[3:0], carry_reg. Sum nibble shifts into the top of result_reg, both operand regs shift right by 4, carry_reg<=slice carry, idx++. On the cycle with idx==N_NIBBLES-1, compute flags and go to OUT.
- ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is B after conditional inversion. Use the MSBs captured on the last slice.
- zero is computed from the complete result.
- OUT: out_valid=1; result and flags stable. On out_ready: if in_valid is also high, accept the new operands in the same cycle and go to RUN (back-to-back); otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==OUT && out_ready). Inputs are ignored when in_ready=0.
- Reset, asserted at any time including mid-RUN or in OUT: state IDLE; in_valid/result/cout/ovf/zero/out_valid all 0; internal regs cleared; in_ready=1 once rst deasserts. A partial operation is discarded with no output.

## Timing
- Accept at edge T (in_valid && in_ready).
- RUN occupies cycles T+1 .. T+N_NIBBLES.
- out_valid rises at cycle T+N_NIBBLES+1. Latency is N_NIBBLES+1 cycles; 5 at default.
- Throughput under back-to-back traffic: one result per N_NIBBLES+1 cycles. The OUT cycle doubles as the accept cycle.
- result, cout, ovf and zero change only on entry to OUT. Between operations they hold their last values; they are never X after reset.
- out_ready outside OUT has no effect.
- in_valid held high during RUN does not queue a second request.

## Structure
- Shared package holds:
  - state enum {IDLE, RUN, OUT};
  - NIBBLE_W = 4;
  - the idx width function clog2(N_NIBBLES), minimum 1.
- One sub-module: nibble_addsub_slice. It instantiates the team's existing 4-bit ripple-carry adder and exposes sum[3:0], cout, and sum_msb. The controller instantiates exactly one slice.
- All sequencing, shifting and flag logic lives in serial_addsub_ctrl.

## Test plan
- Add, W=16: 0x1234 + 0x0FFF -> result 0x2233, cout 0, ovf 0, zero 0; out_valid exactly 5 cycles after accept.
- Signed overflow on add: 0x7FFF + 0x0001 -> 0x8000, cout 0, ovf 1. Wrap with zero: 0xFFFF + 0x0001 -> 0x0000, cout 1, ovf 0, zero 1.
- Subtract: 0x0005 - 0x0007 -> 0xFFFE, cout 0 (borrow), ovf 0. Subtract overflow: 0x8000 - 0x0001 -> 0x7FFF, cout 1, ovf 1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 3 cycles in OUT: result is stable and in_ready=0.
  - Then raise out_ready together with in_valid: the new pair is accepted on the same edge, and the next out_valid arrives 5 cycles later.
- Reset mid-RUN: assert rst at cycle T+2 -> all outputs 0 immediately and no out_valid for that operation. After release, a fresh 0x0001 + 0x0001 -> 0x0002.
- N_NIBBLES=1 instance: 0xF + 0x1 -> 0x0, cout 1, zero 1; latency 2 cycles.
